// File: rtl/tdc_meas_ctrl.sv
// rtl/tdc_meas_ctrl.sv - TDC measurement controller: launch, synchronise, thermometer-encode, hand off
//
// Ports:
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_i       measurement request, sampled only in IDLE
//   pulse_o       registered one-cycle launch pulse into the delay line
//   dl_tap_i      N delay-line taps, asynchronous to clk
//   meas_valid_o  result available (valid/ready handshake)
//   meas_ready_i  consumer accepts the result
//   result_o      population count of the captured tap word (0..N)
//   bubble_o      captured word was not a clean thermometer code
//   overflow_o    every tap was set
//   busy_o        state is not IDLE
//   meas_cnt_o    completed-handshake counter, wraps modulo 2^16
module tdc_meas_ctrl #(
    parameter int N            = 64,
    parameter int DRAIN_CYCLES = 8,
    localparam int RW          = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    output logic          pulse_o,
    input  logic [N-1:0]  dl_tap_i,
    output logic          meas_valid_o,
    input  logic          meas_ready_i,
    output logic [RW-1:0] result_o,
    output logic          bubble_o,
    output logic          overflow_o,
    output logic          busy_o,
    output logic [15:0]   meas_cnt_o
);

    localparam int DW = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        SYNC   = 3'd2,
        ENCODE = 3'd3,
        RESULT = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            pulse_q, pulse_d;
    logic            valid_q, valid_d;
    logic [RW-1:0]   result_q, result_d;
    logic            bubble_q, bubble_d;
    logic            overflow_q, overflow_d;
    logic [15:0]     meas_cnt_q, meas_cnt_d;
    logic [DW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [N-1:0]    cap_q, cap_d;
    logic [N-1:0]    sync_q, sync_d;

    logic [RW-1:0]   pop_cnt;
    logic [N:0]      therm_mask;

    // Encoder on the synchronised word. The mask is built one bit wider so
    // that a full count (pop_cnt == N) still yields an all-ones N-bit mask.
    always_comb begin
        pop_cnt = '0;
        for (int i = 0; i < N; i++) begin
            pop_cnt = pop_cnt + RW'(sync_q[i]);
        end
        therm_mask = ({{N{1'b0}}, 1'b1} << pop_cnt) - {{N{1'b0}}, 1'b1};
    end

    always_comb begin
        state_d     = state_q;
        pulse_d     = pulse_q;
        valid_d     = valid_q;
        result_d    = result_q;
        bubble_d    = bubble_q;
        overflow_d  = overflow_q;
        meas_cnt_d  = meas_cnt_q;
        cap_d       = cap_q;
        sync_d      = sync_q;
        // Drain countdown runs freely once loaded; only LAUNCH reloads it.
        drain_cnt_d = (drain_cnt_q != '0) ? drain_cnt_q - DW'(1) : drain_cnt_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LAUNCH;
                    pulse_d = 1'b1;
                end
            end
            LAUNCH: begin
                cap_d       = dl_tap_i;
                pulse_d     = 1'b0;
                drain_cnt_d = DW'(DRAIN_CYCLES);
                state_d     = SYNC;
            end
            SYNC: begin
                sync_d  = cap_q;
                state_d = ENCODE;
            end
            ENCODE: begin
                result_d   = pop_cnt;
                bubble_d   = (sync_q != therm_mask[N-1:0]);
                overflow_d = &sync_q;
                valid_d    = 1'b1;
                state_d    = RESULT;
            end
            RESULT: begin
                if (meas_ready_i) begin
                    valid_d    = 1'b0;
                    meas_cnt_d = meas_cnt_q + 16'd1;
                    state_d    = (drain_cnt_q == '0) ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt_q <= DW'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pulse_q     <= 1'b0;
            valid_q     <= 1'b0;
            result_q    <= '0;
            bubble_q    <= 1'b0;
            overflow_q  <= 1'b0;
            meas_cnt_q  <= '0;
            drain_cnt_q <= '0;
            cap_q       <= '0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            pulse_q     <= pulse_d;
            valid_q     <= valid_d;
            result_q    <= result_d;
            bubble_q    <= bubble_d;
            overflow_q  <= overflow_d;
            meas_cnt_q  <= meas_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            cap_q       <= cap_d;
            sync_q      <= sync_d;
        end
    end

    assign pulse_o      = pulse_q;
    assign meas_valid_o = valid_q;
    assign result_o     = result_q;
    assign bubble_o     = bubble_q;
    assign overflow_o   = overflow_q;
    assign meas_cnt_o   = meas_cnt_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// tb/tb_tdc_meas_ctrl.sv - directed self-checking bench for tdc_meas_ctrl (N=8, DRAIN_CYCLES=4)
module tb_tdc_meas_ctrl;

    localparam int N  = 8;
    localparam int DC = 4;
    localparam int RW = $clog2(N + 1);

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          pulse_o;
    logic [N-1:0]  dl_tap_i;
    logic          meas_valid_o;
    logic          meas_ready_i;
    logic [RW-1:0] result_o;
    logic          bubble_o;
    logic          overflow_o;
    logic          busy_o;
    logic [15:0]   meas_cnt_o;

    int n_cmp  = 0;
    int n_miss = 0;
    int exp_cnt = 0;

    tdc_meas_ctrl #(.N(N), .DRAIN_CYCLES(DC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .pulse_o      (pulse_o),
        .dl_tap_i     (dl_tap_i),
        .meas_valid_o (meas_valid_o),
        .meas_ready_i (meas_ready_i),
        .result_o     (result_o),
        .bubble_o     (bubble_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o),
        .meas_cnt_o   (meas_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy_o && k < 20) begin
            tick();
            k++;
        end
        chk(tag, 32'(busy_o), 32'd0);
    endtask

    // One measurement with ready held high; checks timing T0..T5 and outputs.
    task automatic do_meas(input string tag, input logic [N-1:0] tap,
                           input int exp_res, input logic exp_bub, input logic exp_ovf);
        @(negedge clk);
        dl_tap_i     = tap;
        start_i      = 1'b1;
        meas_ready_i = 1'b1;
        tick();                                             // T0
        start_i = 1'b0;
        chk({tag, "_pulse_t0"}, 32'(pulse_o), 32'd1);
        chk({tag, "_busy_t0"},  32'(busy_o),  32'd1);
        tick();                                             // T1
        chk({tag, "_pulse_t1"}, 32'(pulse_o), 32'd0);
        chk({tag, "_valid_t1"}, 32'(meas_valid_o), 32'd0);
        tick();                                             // T2
        chk({tag, "_valid_t2"}, 32'(meas_valid_o), 32'd0);
        tick();                                             // T3
        chk({tag, "_valid_t3"}, 32'(meas_valid_o), 32'd1);
        chk({tag, "_result"},   32'(result_o),   32'(exp_res));
        chk({tag, "_bubble"},   32'(bubble_o),   32'(exp_bub));
        chk({tag, "_overflow"}, 32'(overflow_o), 32'(exp_ovf));
        tick();                                             // T4 handshake
        exp_cnt = (exp_cnt + 1) % 65536;
        chk({tag, "_valid_t4"}, 32'(meas_valid_o), 32'd0);
        chk({tag, "_cnt"},      32'(meas_cnt_o),   32'(exp_cnt));
        chk({tag, "_drain_t4"}, 32'(busy_o),       32'd1);
        tick();                                             // T5 drain done
        chk({tag, "_idle_t5"},  32'(busy_o),       32'd0);
        chk({tag, "_hold"},     32'(result_o),     32'(exp_res));
    endtask

    initial begin
        int e, first_rise, first_fall, second_rise, rises;
        rst_n        = 1'b0;
        start_i      = 1'b0;
        meas_ready_i = 1'b0;
        dl_tap_i     = '0;
        #12;
        chk("rst_pulse",  32'(pulse_o),      32'd0);
        chk("rst_valid",  32'(meas_valid_o), 32'd0);
        chk("rst_result", 32'(result_o),     32'd0);
        chk("rst_bubble", 32'(bubble_o),     32'd0);
        chk("rst_ovf",    32'(overflow_o),   32'd0);
        chk("rst_busy",   32'(busy_o),       32'd0);
        chk("rst_cnt",    32'(meas_cnt_o),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_meas("m1f", 8'b0001_1111, 5, 1'b0, 1'b0);
        do_meas("m17", 8'b0001_0111, 4, 1'b1, 1'b0);
        do_meas("mff", 8'hFF,        8, 1'b0, 1'b1);
        do_meas("m00", 8'h00,        0, 1'b0, 1'b0);
        do_meas("m80", 8'h80,        1, 1'b1, 1'b0);

        // Backpressure: ready low for 10 cycles after valid.
        @(negedge clk);
        dl_tap_i     = 8'b0000_0111;
        start_i      = 1'b1;
        meas_ready_i = 1'b0;
        tick();
        start_i = 1'b0;
        tick();
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid",  32'(meas_valid_o), 32'd1);
            chk("bp_result", 32'(result_o),     32'd3);
            chk("bp_bubble", 32'(bubble_o),     32'd0);
            chk("bp_busy",   32'(busy_o),       32'd1);
            tick();
        end
        @(negedge clk);
        meas_ready_i = 1'b1;
        tick();
        exp_cnt++;
        chk("bp_valid_done", 32'(meas_valid_o), 32'd0);
        chk("bp_no_drain",   32'(busy_o),       32'd0);
        chk("bp_cnt",        32'(meas_cnt_o),   32'(exp_cnt));

        // Drain: start held high; second launch 5 edges after first fall.
        @(negedge clk);
        dl_tap_i = 8'b0000_0011;
        start_i  = 1'b1;
        first_rise = -1; first_fall = -1; second_rise = -1; rises = 0;
        for (e = 0; e < 12; e++) begin
            tick();
            if (pulse_o) begin
                if (first_rise < 0) first_rise = e;
                else if (first_fall >= 0 && second_rise < 0) second_rise = e;
                rises++;
            end else if (first_rise >= 0 && first_fall < 0) begin
                first_fall = e;
            end
        end
        @(negedge clk);
        start_i = 1'b0;
        chk("dr_first_rise", 32'(first_rise), 32'd0);
        chk("dr_gap",        32'(second_rise - first_fall), 32'd5);
        chk("dr_pulses",     32'(rises), 32'd2);
        exp_cnt++;
        wait_idle("dr_idle_wait");
        exp_cnt++;
        chk("dr_cnt", 32'(meas_cnt_o), 32'(exp_cnt));

        // Reset in the middle of LAUNCH, between clock edges.
        @(negedge clk);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("rs_pulse_pre", 32'(pulse_o), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_pulse",  32'(pulse_o),      32'd0);
        chk("rs_valid",  32'(meas_valid_o), 32'd0);
        chk("rs_cnt",    32'(meas_cnt_o),   32'd0);
        chk("rs_busy",   32'(busy_o),       32'd0);
        chk("rs_result", 32'(result_o),     32'd0);
        #2;
        rst_n = 1'b1;
        exp_cnt = 0;
        do_meas("post_rst", 8'b0011_1111, 6, 1'b0, 1'b0);

        // Wrap: preload the counter near its top, then two handshakes.
        @(negedge clk);
        force dut.meas_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.meas_cnt_q;
        exp_cnt = 16'hFFFE;
        do_meas("wrap1", 8'b0000_0001, 1, 1'b0, 1'b0);
        chk("wrap_ffff", 32'(meas_cnt_o), 32'h0000_FFFF);
        do_meas("wrap2", 8'b0000_0001, 1, 1'b0, 1'b0);
        chk("wrap_zero", 32'(meas_cnt_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_miss);
        $finish;
    end

endmodule
